// File: rtl/gate_driver.sv
// Gate actuator: moves a modelled gate between closed (0) and open (TRAVEL)
// one position per enabled cycle, reversing mid-travel on a request change
// and counting completed openings (saturating).
//
// state     | meaning
// ----------+------------------------------------------------
// S_CLOSED  | at rest, fully closed (Position = 0)
// S_OPENING | travelling toward open (paused while Enable = 0)
// S_OPEN    | at rest, fully open (Position = TRAVEL)
// S_CLOSING | travelling toward closed (paused while Enable = 0)
module gate_driver #(
    parameter int TRAVEL = 10,
    parameter int TW     = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          OpenClose,
    input  logic          Enable,
    output logic          MotorOpen,
    output logic          MotorClose,
    output logic          GateOpen,
    output logic          GateClosed,
    output logic          Busy,
    output logic [TW-1:0] Position,
    output logic [7:0]    OpenCount
);

    typedef enum logic [1:0] {
        S_CLOSED  = 2'd0,
        S_OPENING = 2'd1,
        S_OPEN    = 2'd2,
        S_CLOSING = 2'd3
    } state_t;

    localparam logic [TW-1:0] TRAVEL_V = TW'(TRAVEL);
    localparam logic [TW-1:0] ONE_V    = TW'(1);

    state_t        state_q, state_d;
    logic [TW-1:0] pos_q, pos_d;
    logic [7:0]    cnt_q, cnt_d;

    // State, position and opening-count registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_CLOSED;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and position update; the ">=" / "<=" end checks also cover a
    // reversal taken right at an end stop, which completes on the next motion
    // edge instead of stepping outside [0, TRAVEL].
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLOSED: begin
                if (OpenClose && Enable) state_d = S_OPENING;
            end
            S_OPENING: begin
                if (!OpenClose) begin
                    state_d = S_CLOSING;
                end else if (Enable) begin
                    if (pos_q >= TRAVEL_V - ONE_V) begin
                        pos_d   = TRAVEL_V;
                        state_d = S_OPEN;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end else begin
                        pos_d = pos_q + ONE_V;
                    end
                end
            end
            S_OPEN: begin
                if (!OpenClose && Enable) state_d = S_CLOSING;
            end
            S_CLOSING: begin
                if (OpenClose) begin
                    state_d = S_OPENING;
                end else if (Enable) begin
                    if (pos_q <= ONE_V) begin
                        pos_d   = '0;
                        state_d = S_CLOSED;
                    end else begin
                        pos_d = pos_q - ONE_V;
                    end
                end
            end
            default: state_d = S_CLOSED;
        endcase
    end

    // Output decode; motor commands are the only paths from inputs to outputs
    assign GateOpen   = (state_q == S_OPEN);
    assign GateClosed = (state_q == S_CLOSED);
    assign Busy       = (state_q == S_OPENING) || (state_q == S_CLOSING);
    assign MotorOpen  = (state_q == S_OPENING) && Enable;
    assign MotorClose = (state_q == S_CLOSING) && Enable;
    assign Position   = pos_q;
    assign OpenCount  = cnt_q;

endmodule

// File: doc/gate_driver.md
# gate_driver

Gate actuator stage that sits directly downstream of the switch-driven open/close port controller. It takes the level `OpenClose` request (1 = open, 0 = closed) and moves a modelled gate between fully closed and fully open over a fixed travel time. Motion pauses while the `Enable` interlock is low, and a request change mid-travel reverses direction from the current position. It drives the motor commands, limit indications, gate position and a saturating count of completed openings.

## Interface
- `TRAVEL`, 10: number of motion cycles for full travel; legal range 1 ≤ TRAVEL ≤ 2^TW−1.
- `TW`, 4: width of `Position`.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  reset, asynchronous, active-low.
- `OpenClose`  in  1  requested gate state from the upstream port controller (1 = open); synchronous to `Clock`.
- `Enable`  in  1  motion interlock; 0 freezes motion.
- `MotorOpen`  out  1  drive gate toward open.
- `MotorClose`  out  1  drive gate toward closed.
- `GateOpen`  out  1  gate fully open.
- `GateClosed`  out  1  gate fully closed.
- `Busy`  out  1  travel in progress, whether moving or paused.
- `Position`  out  TW  current position: 0 = closed, TRAVEL = open.
- `OpenCount`  out  8  completed openings, saturating.

## Operation
- States: CLOSED, OPENING, OPEN, CLOSING.
- Reset (`Reset`=0, asynchronous):
  - state CLOSED, `Position`=0, `OpenCount`=0.
  - Outputs: `GateClosed`=1; `MotorOpen`, `MotorClose`, `GateOpen` and `Busy` all 0.
- CLOSED: if `OpenClose`=1 and `Enable`=1, go to OPENING with `Position` held. Otherwise stay.
- OPENING:
  - `OpenClose`=0: go to CLOSING, `Position` held for that edge. This applies regardless of `Enable`.
  - Else if `Enable`=1: `Position`+1. If the new value equals TRAVEL, go to OPEN and increment `OpenCount` (saturates at 255).
  - Else (`Enable`=0): hold.
- OPEN: if `OpenClose`=0 and `Enable`=1, go to CLOSING with `Position` held. Otherwise stay.
- CLOSING:
  - `OpenClose`=1: go to OPENING, `Position` held for that edge. This applies regardless of `Enable`.
  - Else if `Enable`=1: `Position`−1. If the new value equals 0, go to CLOSED.
  - Else (`Enable`=0): hold.
- Output decode:
  - `GateOpen` = (state==OPEN); `GateClosed` = (state==CLOSED); `Busy` = (state==OPENING or CLOSING).
  - `MotorOpen` = (state==OPENING) & `Enable`; `MotorClose` = (state==CLOSING) & `Enable`. These are the only combinational input-to-output paths.
  - `MotorOpen` and `MotorClose` are never both 1.
- Arithmetic:
  - `Position` is unsigned TW-bit and never leaves [0, TRAVEL].
  - `OpenCount` is unsigned 8-bit and never wraps.
- Reversal never increments `OpenCount`. Only the OPENING→OPEN transition increments it.

## Timing
- Request to start of motion: 1 edge. The edge that sees the request enters OPENING/CLOSING, and the motor output asserts in the cycle after that edge (with `Enable`=1).
- Full travel from rest: `GateOpen` (or `GateClosed`) asserts after TRAVEL+1 rising edges from the first edge that samples the changed request, with `Enable` held 1.
- Reversal at position p:
  - 1 edge of direction change, then p edges to CLOSED (when closing) or TRAVEL−p edges to OPEN (when opening).
- Pause: each edge with `Enable`=0 in OPENING/CLOSING extends completion by exactly 1 edge. `Busy` stays 1 throughout.
- Requests in OPEN/CLOSED with `Enable`=0 are not lost. Motion starts on the first edge where the request and `Enable`=1 coincide.
- TRAVEL=1 corner: OPENING→OPEN on the first motion edge; CLOSING→CLOSED likewise.
- Reset deassertion: the first state change can occur on the first rising edge after `Reset` returns to 1.

## Test plan
- **Full open:** TRAVEL=10; reset, then `Enable`=1, `OpenClose`=1.
  - `MotorOpen`=1 after edge 1.
  - `Position` reaches 10 and `GateOpen`=1, `Busy`=0, `OpenCount`=1 after edge 11.
- **Full close:** from OPEN, `OpenClose`=0 → `GateClosed`=1 and `Position`=0 after 11 edges; `OpenCount` stays 1.
- **Reversal:** opening, drop `OpenClose` when `Position`=4.
  - Next edge: CLOSING with `Position`=4.
  - Then 3, 2, 1, 0, with CLOSED on the 4th decrement.
  - `OpenCount` unchanged; motor outputs never both 1.
- **Interlock pause:** `Enable`=0 for 5 cycles at `Position`=6 while opening.
  - `Position` stays 6, `MotorOpen`=0, `Busy`=1.
  - After `Enable` returns, `GateOpen` arrives exactly 5 edges later than the unpaused case.
- **Async reset mid-travel:** assert `Reset`=0 between edges at `Position`=7.
  - Immediately (no clock edge): `Position`=0, `GateClosed`=1, `Busy`=0, `MotorOpen`=0, `OpenCount`=0.
- **Saturation:** 260 complete open/close cycles → `OpenCount` reads 255 and stays 255.
